wb_port_arbiter: RTL and testbench

N-port memory request arbiter bridging pipeline-side word ports (fetch, load/store, future DMA/debug) onto one wide Wishbone master. It generalises the fixed two-port fetch/data memory path to NUM_PORTS requesters with selectable arbitration. It adds bounded retry on wb_rty_i and per-port error reporting. One transaction is outstanding at a time; there is no caching.

---
 rtl/wb_port_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// N-port word request arbiter onto a single wide Wishbone master.
// One access in flight; round-robin or fixed-priority grant, bounded retry on wb_rty_i.
module wb_port_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int BUS_WIDTH       = 128,
    parameter int BUS_GRANULARITY = 32,
    parameter int MAX_RETRY       = 4,
    parameter int PRIORITY_MODE   = 0
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_PORTS-1:0]                     req_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]          req_addr,
    input  logic [NUM_PORTS*BUS_GRANULARITY-1:0]     req_wdata,
    input  logic [NUM_PORTS-1:0]                     req_wr,
    output logic [NUM_PORTS*BUS_GRANULARITY-1:0]     req_rdata,
    output logic [NUM_PORTS-1:0]                     req_done,
    output logic [NUM_PORTS-1:0]                     req_err,
    output logic [ADDR_WIDTH-1:0]                    wb_adr_o,
    output logic [BUS_WIDTH-1:0]                     wb_dat_o,
    input  logic [BUS_WIDTH-1:0]                     wb_dat_i,
    output logic                                     wb_we_o,
    output logic [BUS_WIDTH/BUS_GRANULARITY-1:0]     wb_sel_o,
    output logic                                     wb_stb_o,
    output logic                                     wb_cyc_o,
    input  logic                                     wb_ack_i,
    input  logic                                     wb_err_i,
    input  logic                                     wb_rty_i
);

    localparam int SEL_WIDTH = BUS_WIDTH / BUS_GRANULARITY;
    localparam int LANE_BITS = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1;
    localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int RTY_W     = $clog2(MAX_RETRY + 1);
    localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(SEL_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_RESP} state_e;

    state_e                               state_q, state_d;
    logic [PTR_W-1:0]                     ptr_q, ptr_d;
    logic [PTR_W-1:0]                     grant_q, grant_d;
    logic [LANE_BITS-1:0]                 lane_q, lane_d;
    logic [RTY_W-1:0]                     retry_q, retry_d;
    logic [ADDR_WIDTH-1:0]                adr_q, adr_d;
    logic [BUS_WIDTH-1:0]                 dat_q, dat_d;
    logic                                 we_q, we_d;
    logic [SEL_WIDTH-1:0]                 sel_q, sel_d;
    logic                                 cyc_q, cyc_d;
    logic [NUM_PORTS-1:0]                 done_q, done_d;
    logic [NUM_PORTS-1:0]                 rerr_q, rerr_d;
    logic [NUM_PORTS*BUS_GRANULARITY-1:0] rdata_q, rdata_d;

    logic                                 gnt_found;
    logic [PTR_W-1:0]                     gnt_idx;
    logic [ADDR_WIDTH-1:0]                sel_addr;
    logic [BUS_GRANULARITY-1:0]           sel_wdata;
    logic [LANE_BITS-1:0]                 sel_lane;
    logic [BUS_GRANULARITY-1:0]           lane_word;
    logic [RTY_W-1:0]                     retry_inc;
    logic                                 resp_go;
    logic                                 resp_err;
    logic [BUS_GRANULARITY-1:0]           resp_word;

    // Round-robin scans upward from the port after the last winner, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        if (PRIORITY_MODE == 1) begin
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                if (req_valid[k]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PTR_W'(k);
                end
            end
        end else begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                if (!gnt_found && req_valid[(int'(ptr_q) + k) % NUM_PORTS]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = PTR_W'((int'(ptr_q) + k) % NUM_PORTS);
                end
            end
        end
    end

    assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[int'(gnt_idx)*BUS_GRANULARITY +: BUS_GRANULARITY];
    assign sel_lane  = LANE_BITS'(sel_addr & LANE_MASK);
    assign lane_word = wb_dat_i[int'(lane_q)*BUS_GRANULARITY +: BUS_GRANULARITY];
    assign retry_inc = retry_q + RTY_W'(1);

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        lane_d    = lane_q;
        retry_d   = retry_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        sel_d     = sel_q;
        done_d    = '0;
        rerr_d    = '0;
        rdata_d   = rdata_q;
        resp_go   = 1'b0;
        resp_err  = 1'b0;
        resp_word = '0;

        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    grant_d = gnt_idx;
                    if (PRIORITY_MODE == 0) ptr_d = gnt_idx;
                    lane_d  = sel_lane;
                    adr_d   = sel_addr & ~LANE_MASK;
                    dat_d   = {SEL_WIDTH{sel_wdata}};
                    we_d    = req_wr[gnt_idx];
                    sel_d   = SEL_WIDTH'(1) << sel_lane;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // ack outranks err, which outranks rty, when several arrive together.
                if (wb_ack_i) begin
                    resp_go   = 1'b1;
                    resp_word = we_q ? '0 : lane_word;
                end else if (wb_err_i) begin
                    resp_go  = 1'b1;
                    resp_err = 1'b1;
                end else if (wb_rty_i) begin
                    retry_d = retry_inc;
                    if (retry_inc == RTY_W'(MAX_RETRY)) begin
                        resp_go  = 1'b1;
                        resp_err = 1'b1;
                    end else begin
                        state_d = S_BACKOFF;
                    end
                end
            end
            S_BACKOFF: state_d = S_BUS;
            S_RESP: begin
                retry_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (resp_go) begin
            state_d          = S_RESP;
            done_d[grant_q]  = 1'b1;
            rerr_d[grant_q]  = resp_err;
            rdata_d[int'(grant_q)*BUS_GRANULARITY +: BUS_GRANULARITY] = resp_word;
        end
    end

    // Strobe is registered from the next state, so it is high exactly while in BUS.
    assign cyc_d = (state_d == S_BUS);

    // NOTE: sequential state uses <= so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_W'(NUM_PORTS - 1);
            grant_q <= '0;
            lane_q  <= '0;
            retry_q <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            cyc_q   <= 1'b0;
            done_q  <= '0;
            rerr_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            lane_q  <= lane_d;
            retry_q <= retry_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            cyc_q   <= cyc_d;
            done_q  <= done_d;
            rerr_q  <= rerr_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_rdata = rdata_q;
    assign req_done  = done_q;
    assign req_err   = rerr_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_stb_o  = cyc_q;
    assign wb_cyc_o  = cyc_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed steps plus randomized traffic against a transaction-level model.
// A second instance in fixed-priority mode is exercised for the starvation-order case.
module tb_wb_port_arbiter;

    localparam int NP        = 2;
    localparam int AW        = 32;
    localparam int BW        = 128;
    localparam int GW        = 32;
    localparam int SEL       = BW / GW;
    localparam int MAX_RETRY = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP-1:0]   m_valid, f_valid, req_wr;
    logic [NP*AW-1:0] req_addr;
    logic [NP*GW-1:0] req_wdata;
    logic [BW-1:0]   wb_dat_i;
    logic            wb_ack_i, wb_err_i, wb_rty_i;

    logic [NP*GW-1:0] req_rdata, f_rdata;
    logic [NP-1:0]    req_done, req_err, f_done, f_err;
    logic [AW-1:0]    wb_adr_o, f_adr;
    logic [BW-1:0]    wb_dat_o, f_dat;
    logic [SEL-1:0]   wb_sel_o, f_sel;
    logic             wb_we_o, wb_stb_o, wb_cyc_o, f_we, f_stb, f_cyc;

    wb_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .BUS_GRANULARITY(GW),
        .MAX_RETRY(MAX_RETRY), .PRIORITY_MODE(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(m_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wr(req_wr),
        .req_rdata(req_rdata), .req_done(req_done), .req_err(req_err),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    wb_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .BUS_WIDTH(BW), .BUS_GRANULARITY(GW),
        .MAX_RETRY(MAX_RETRY), .PRIORITY_MODE(1)
    ) u_fix (
        .clk(clk), .rst_n(rst_n),
        .req_valid(f_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wr(req_wr),
        .req_rdata(f_rdata), .req_done(f_done), .req_err(f_err),
        .wb_adr_o(f_adr), .wb_dat_o(f_dat), .wb_dat_i(wb_dat_i), .wb_we_o(f_we),
        .wb_sel_o(f_sel), .wb_stb_o(f_stb), .wb_cyc_o(f_cyc),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 clk = ~clk;

    // Reference model state: pending requests per port, last delivered word per port, RR pointer.
    bit          pv[NP];
    logic [31:0] pa[NP];
    logic [31:0] pw[NP];
    bit          pwr[NP];
    logic [31:0] exp_rd[NP];
    int          m_ptr;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NP*GW-1:0] pack_rd();
        logic [NP*GW-1:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) v[p*GW +: GW] = exp_rd[p];
        return v;
    endfunction

    // Round-robin rule: first pending port after the previous winner, wrapping around.
    function automatic int pick();
        for (int k = 1; k <= NP; k++) begin
            if (pv[(m_ptr + k) % NP]) return (m_ptr + k) % NP;
        end
        return 0;
    endfunction

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            m_valid[p]            = pv[p];
            req_addr[p*AW +: AW]  = pa[p];
            req_wdata[p*GW +: GW] = pw[p];
            req_wr[p]             = pwr[p];
        end
    endtask

    task automatic issue(input int p, input logic [31:0] a, input logic [31:0] w, input bit wr);
        pv[p]  = 1'b1;
        pa[p]  = a;
        pw[p]  = w;
        pwr[p] = wr;
        drive();
    endtask

    task automatic wait_stb(input string tag);
        int n = 0;
        while (wb_stb_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, wb_stb_o, 1'b1);
    endtask

    // Serve one access: rty_n retries first, then final response kind
    // (0 ack, 1 err, 2 ack+err+rty, 3 err+rty); wait_n idle cycles before each response.
    task automatic serve(input int rty_n, input int wait_n, input int kind,
                         input logic [127:0] line, output int g);
        int          lane;
        int          attempts;
        int          exp_att;
        bit          fin;
        bit          exp_err;
        logic [31:0] exp_word;
        g     = pick();
        m_ptr = g;
        lane  = int'(pa[g] % SEL);
        wait_stb("grant_stb");
        check("wb_adr", wb_adr_o, pa[g] - 32'(lane));
        check("wb_sel", wb_sel_o, 1 << lane);
        check("wb_we", wb_we_o, pwr[g]);
        check("wb_dat", wb_dat_o, {SEL{pw[g]}});
        attempts = 0;
        fin = 1'b0;
        for (int a = 0; !fin && a < 16; a++) begin
            check("attempt_stb", wb_stb_o, 1'b1);
            if (wb_stb_o === 1'b1) attempts++;
            repeat (wait_n) tick();
            wb_dat_i = line;
            if (a < rty_n) begin
                wb_rty_i = 1'b1;
            end else begin
                case (kind)
                    1:       wb_err_i = 1'b1;
                    2:       begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_rty_i = 1'b1; end
                    3:       begin wb_err_i = 1'b1; wb_rty_i = 1'b1; end
                    default: wb_ack_i = 1'b1;
                endcase
            end
            tick();
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_rty_i = 1'b0;
            if (a < rty_n && a + 1 < MAX_RETRY) begin
                check("backoff_stb", wb_stb_o, 1'b0);
                tick();
            end else begin
                fin = 1'b1;
            end
        end
        exp_err  = (rty_n >= MAX_RETRY) ? 1'b1 : (kind == 1 || kind == 3);
        exp_att  = (rty_n >= MAX_RETRY) ? MAX_RETRY : rty_n + 1;
        exp_word = (exp_err || pwr[g]) ? 32'h0 : line[lane*GW +: GW];
        exp_rd[g] = exp_word;
        check("done", req_done, 1 << g);
        check("err", req_err, exp_err ? (1 << g) : 0);
        check("rdata", req_rdata, pack_rd());
        check("cyc_resp", wb_cyc_o, 1'b0);
        check("attempts", attempts, exp_att);
        pv[g] = 1'b0;
        drive();
        tick();
        check("done_pulse", req_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int             g;
        logic [127:0]   line;
        logic [7:0]     order;
        int             rem[NP];
        int             total;
        int             rty_n;
        int             kind;
        int             r;
        bit             any;

        m_valid = '0; f_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        m_ptr = NP - 1;
        for (int p = 0; p < NP; p++) begin
            pv[p] = 1'b0; pa[p] = '0; pw[p] = '0; pwr[p] = 1'b0; exp_rd[p] = '0;
        end

        tick();
        tick();
        check("rst_done", req_done, 0);
        check("rst_err", req_err, 0);
        check("rst_rdata", req_rdata, 0);
        check("rst_adr", wb_adr_o, 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_sel", wb_sel_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_cyc", wb_cyc_o, 0);
        rst_n = 1'b1;
        tick();

        // Port 0 read of word 6: lane 2 of line at 0x4, one wait cycle.
        line = {$urandom, 32'hDEADBEEF, $urandom, $urandom};
        issue(0, 32'h0000_0006, $urandom, 1'b0);
        serve(0, 1, 0, line, g);
        check("tp1_port", g, 0);
        check("tp1_word", req_rdata[31:0], 32'hDEADBEEF);

        // Port 1 write of word 9.
        issue(1, 32'h0000_0009, 32'h1234_5678, 1'b1);
        serve(0, 0, 0, {$urandom, $urandom, $urandom, $urandom}, g);
        check("tp2_port", g, 1);

        // Both ports continuously requesting, round-robin.
        rem[0] = 4; rem[1] = 4; order = '0;
        issue(0, $urandom, $urandom, 1'b0);
        issue(1, $urandom, $urandom, 1'b0);
        for (int n = 0; n < 8; n++) begin
            serve(0, 0, 0, {$urandom, $urandom, $urandom, $urandom}, g);
            order[n] = g[0];
            rem[g]--;
            if (rem[g] > 0) issue(g, $urandom, $urandom, 1'b0);
        end
        check("rr_order", order, 8'b1010_1010);

        // Same contention on the fixed-priority instance with an always-acking slave.
        rem[0] = 4; rem[1] = 4; order = '0; total = 0;
        wb_ack_i = 1'b1;
        f_valid  = 2'b11;
        for (int c = 0; c < 200 && total < 8; c++) begin
            tick();
            if (f_done !== 2'b00) begin
                r = f_done[1] ? 1 : 0;
                order[total] = r[0];
                total++;
                rem[r]--;
                if (rem[r] == 0) f_valid[r] = 1'b0;
            end
        end
        wb_ack_i = 1'b0;
        f_valid  = '0;
        check("fix_count", total, 8);
        check("fix_order", order, 8'b1111_0000);
        repeat (3) tick();

        // Retries: two rty then ack; four rty exhausts; plain err; simultaneous responses.
        issue(0, $urandom, $urandom, 1'b0);
        serve(2, 0, 0, {$urandom, $urandom, $urandom, $urandom}, g);
        issue(1, $urandom, $urandom, 1'b0);
        serve(4, 1, 0, {$urandom, $urandom, $urandom, $urandom}, g);
        issue(0, $urandom, $urandom, 1'b0);
        serve(0, 2, 1, {$urandom, $urandom, $urandom, $urandom}, g);
        issue(1, $urandom, $urandom, 1'b0);
        serve(0, 0, 2, {$urandom, $urandom, $urandom, $urandom}, g);
        issue(0, $urandom, $urandom, 1'b1);
        serve(1, 1, 3, {$urandom, $urandom, $urandom, $urandom}, g);

        // Randomized traffic: ports join while others are pending.
        for (int it = 0; it < 40; it++) begin
            any = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (!pv[p] && $urandom_range(0, 1) == 1)
                    issue(p, $urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            for (int p = 0; p < NP; p++) if (pv[p]) any = 1'b1;
            if (!any) issue(int'($urandom_range(0, NP - 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            rty_n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            r     = int'($urandom_range(0, 9));
            kind  = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
            serve(rty_n, int'($urandom_range(0, 2)), kind,
                  {$urandom, $urandom, $urandom, $urandom}, g);
        end
        for (int p = 0; p < NP; p++) begin
            if (pv[p]) serve(0, 0, 0, {$urandom, $urandom, $urandom, $urandom}, g);
        end

        // Reset in the middle of a bus cycle: drops strobe at once, no completion.
        issue(0, $urandom, $urandom, 1'b0);
        wait_stb("mr_stb");
        #2 rst_n = 1'b0;
        #1;
        check("mr_cyc", wb_cyc_o, 1'b0);
        check("mr_stb_drop", wb_stb_o, 1'b0);
        check("mr_done", req_done, 0);
        issue(1, $urandom, $urandom, 1'b1);
        tick();
        tick();
        check("mr_done_hold", req_done, 0);
        rst_n = 1'b1;
        m_ptr = NP - 1;
        for (int p = 0; p < NP; p++) exp_rd[p] = '0;
        check("mr_rdata_clear", req_rdata, 0);
        serve(0, 0, 0, {$urandom, $urandom, $urandom, $urandom}, g);
        check("mr_first_port", g, 0);
        serve(0, 1, 0, {$urandom, $urandom, $urandom, $urandom}, g);
        check("mr_second_port", g, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
